// File: rtl/tilemap_scanner.sv
// tilemap_scanner: walks the tile map row by row and hands each cell to the tile drawer.
// Optional build macro TILEMAP_SKIP_EMPTY_EN: empty/out-of-range cells bypass the drawer handshake.
`default_nettype none

module tilemap_scanner #(
  parameter int         MAP_COLS    = 20,
  parameter int         MAP_ROWS    = 15,
  parameter int         TILE_COUNT  = 21,
  parameter logic [7:0] EMPTY_INDEX = 8'hFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [8:0]  map_addr,
  input  logic [7:0]  map_data,
  output logic [11:0] tile_address,
  output logic [7:0]  x_pos,
  output logic [7:0]  y_pos,
  output logic        draw,
  input  logic        drawer_active,
  output logic        busy,
  output logic        done,
  output logic [8:0]  cells_drawn
);

  localparam int         CW      = $clog2(MAP_COLS);
  localparam int         RW      = $clog2(MAP_ROWS);
  localparam logic [7:0] TILE_LIM = 8'(TILE_COUNT);

  typedef enum logic [3:0] {
    S_IDLE, S_READ_REQ, S_READ_WAIT, S_CAPTURE, S_ISSUE,
    S_WAIT_ACK, S_WAIT_DONE, S_ADVANCE, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [8:0]    addr_q, addr_d;
  logic [8:0]    cells_q, cells_d;
  logic [11:0]   tile_q, tile_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic          draw_q, draw_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          w_empty;
  logic          w_last;
  logic [11:0]   w_tile;

  assign w_empty = (map_data == EMPTY_INDEX) || (map_data >= TILE_LIM);
  assign w_last  = (col_q == CW'(MAP_COLS - 1)) && (row_q == RW'(MAP_ROWS - 1));
  // index*192 as two shifts; valid indices never overflow 12 bits
  assign w_tile  = ({4'b0, map_data} << 7) + ({4'b0, map_data} << 6);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    cells_d = cells_q;
    tile_d  = tile_q;
    x_d     = x_q;
    y_d     = y_q;
    draw_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ_REQ;
          busy_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          cells_d = '0;
        end
      end
      S_READ_REQ:  state_d = S_READ_WAIT;
      S_READ_WAIT: state_d = S_CAPTURE;
      S_CAPTURE: begin
        x_d     = 8'(col_q) << 3;
        y_d     = 8'(row_q) << 3;
        tile_d  = w_tile;
        state_d = S_ISSUE;
        if (w_empty) begin
`ifdef TILEMAP_SKIP_EMPTY_EN
          x_d     = x_q;
          y_d     = y_q;
          tile_d  = tile_q;
          state_d = S_ADVANCE;
`else
          tile_d  = '0;
`endif
        end
      end
      S_ISSUE: begin
        // the drawer may still be busy with a tile it was handed elsewhere
        if (!drawer_active) begin
          draw_d  = 1'b1;
          cells_d = cells_q + 9'd1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (drawer_active) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!drawer_active) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (w_last) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (col_q == CW'(MAP_COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          addr_d  = addr_q + 9'd1;
          state_d = S_READ_REQ;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      cells_q <= '0;
      tile_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      draw_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      cells_q <= cells_d;
      tile_q  <= tile_d;
      x_q     <= x_d;
      y_q     <= y_d;
      draw_q  <= draw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign map_addr     = addr_q;
  assign tile_address = tile_q;
  assign x_pos        = x_q;
  assign y_pos        = y_q;
  assign draw         = draw_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cells_drawn  = cells_q;

endmodule

`default_nettype wire

// File: tb/tb_tilemap_scanner.sv
// tb_tilemap_scanner: randomized map scans checked against a queue-based reference of the expected draw stream.
`timescale 1ns/1ps
`default_nettype none

module tb_tilemap_scanner;

  localparam int NCELL = 300;
`ifdef TILEMAP_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  map_addr;
  logic [7:0]  map_data;
  logic [11:0] tile_address;
  logic [7:0]  x_pos, y_pos;
  logic        draw;
  logic        drawer_active = 1'b0;
  logic        busy, done;
  logic [8:0]  cells_drawn;

  tilemap_scanner dut (
    .clk(clk), .resetn(resetn), .start(start),
    .map_addr(map_addr), .map_data(map_data),
    .tile_address(tile_address), .x_pos(x_pos), .y_pos(y_pos),
    .draw(draw), .drawer_active(drawer_active),
    .busy(busy), .done(done), .cells_drawn(cells_drawn)
  );

  always #5 clk = ~clk;

  // synchronous map RAM, two-cycle read latency
  logic [7:0] mem [NCELL];
  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= (map_addr < NCELL) ? mem[map_addr] : 8'h00;
    rd2 <= rd1;
  end
  assign map_data = rd2;

  typedef struct packed {
    logic [11:0] t;
    logic [7:0]  x;
    logic [7:0]  y;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cells = 0;
  int   draws_seen = 0;
  int   done_seen = 0;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic bit is_empty(input logic [7:0] v);
    return (v == 8'hFF) || (v >= 8'd21);
  endfunction

  // reference: every cell in raster order, drawn unless skipped
  task automatic start_scan();
    q.delete();
    exp_cells = 0;
    for (int c = 0; c < NCELL; c++) begin
      if (!(SKIP && is_empty(mem[c]))) begin
        exp_t e;
        e.t = is_empty(mem[c]) ? 12'd0 : 12'(int'(mem[c]) * 192);
        e.x = 8'((c % 20) * 8);
        e.y = 8'((c / 20) * 8);
        q.push_back(e);
        exp_cells++;
      end
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int cnt;
    d0 = done_seen;
    cnt = 0;
    while (done_seen == d0 && cnt < 30000) begin
      @(negedge clk); #1;
      cnt++;
    end
    chk_ok(name, done_seen == d0 + 1, done_seen - d0, 1);
    repeat (3) @(negedge clk);
  endtask

  // monitor / scoreboard
  logic       prev_busy = 1'b0, prev_draw = 1'b0, prev_done = 1'b0;
  logic [8:0] last_addr = 9'd0;
  int         elapsed = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_busy = 1'b0; prev_draw = 1'b0; prev_done = 1'b0;
      last_addr = 9'd0; elapsed = 0;
    end else begin
      elapsed++;
      if (busy && !prev_busy) begin
        draws_seen = 0;
        elapsed = 0;
      end
      if (map_addr != last_addr) begin
        if (map_addr != 9'd0) begin
          chk_eq("addr_step", int'(map_addr), int'(last_addr) + 1);
          if (SKIP && is_empty(mem[last_addr]))
            chk_eq("empty_cell_cycles", elapsed, 4);
          else
            chk_ok("drawn_cell_cycles", elapsed >= 7, elapsed, 7);
        end
        last_addr = map_addr;
        elapsed = 0;
      end
      if (draw) begin
        chk_eq("draw_single_cycle", int'(prev_draw), 0);
        chk_eq("draw_while_active", int'(drawer_active), 0);
        if (q.size() == 0) begin
          chk_ok("unexpected_draw", 1'b0, int'(map_addr), -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk_eq("tile_address", int'(tile_address), int'(e.t));
          chk_eq("x_pos", int'(x_pos), int'(e.x));
          chk_eq("y_pos", int'(y_pos), int'(e.y));
        end
        draws_seen++;
        chk_eq("cells_drawn_running", int'(cells_drawn), draws_seen);
      end
      if (done) begin
        done_seen++;
        chk_eq("done_single_cycle", int'(prev_done), 0);
        chk_eq("cells_drawn_final", int'(cells_drawn), exp_cells);
        chk_eq("draws_left", q.size(), 0);
        chk_eq("busy_at_done", int'(busy), 0);
        chk_eq("last_map_addr", int'(map_addr), 299);
      end
      prev_busy = busy;
      prev_draw = draw;
      prev_done = done;
    end
  end

  // drawer model: goes active a few cycles after draw, sometimes stays busy afterwards
  int tiles = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (draw && resetn) begin
        tiles++;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        drawer_active = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        drawer_active = 1'b0;
        if (tiles % 7 == 3) begin
          @(negedge clk);
          drawer_active = 1'b1;
          repeat (8) @(negedge clk);
          drawer_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    for (int c = 0; c < NCELL; c++) mem[c] = 8'd1;

    #1;
    chk_eq("rst_map_addr", int'(map_addr), 0);
    chk_eq("rst_tile_address", int'(tile_address), 0);
    chk_eq("rst_x_pos", int'(x_pos), 0);
    chk_eq("rst_y_pos", int'(y_pos), 0);
    chk_eq("rst_draw", int'(draw), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_cells_drawn", int'(cells_drawn), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("idle_busy", int'(busy), 0);

    // scan 1: all index 1, cell 21 = index 20, with an ignored start mid-scan
    mem[21] = 8'd20;
    start_scan();
    @(negedge clk); #1;
    chk_eq("busy_after_start", int'(busy), 1);
    cnt = 0;
    while (draws_seen < 20 && cnt < 5000) begin
      @(negedge clk); #1;
      cnt++;
    end
    chk_ok("reach_draw20", draws_seen >= 20, draws_seen, 20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk_eq("midscan_start_cells", int'(cells_drawn), draws_seen);
    chk_eq("midscan_start_busy", int'(busy), 1);
    wait_done("scan1_done");
    chk_eq("scan1_idle_busy", int'(busy), 0);

    // scan 2: odd cells empty, out-of-range indices in cells 0 and 1
    for (int c = 0; c < NCELL; c++) mem[c] = (c % 2) ? 8'hFF : 8'(1 + (c % 20));
    mem[0] = 8'd21;
    mem[1] = 8'd200;
    start_scan();
    wait_done("scan2_done");
    chk_eq("scan2_cells_drawn", int'(cells_drawn), SKIP ? 149 : 300);

    // scan 3: random map
    for (int c = 0; c < NCELL; c++) begin
      case ($urandom_range(0, 3))
        0:       mem[c] = 8'hFF;
        1:       mem[c] = 8'($urandom_range(21, 254));
        default: mem[c] = 8'($urandom_range(0, 20));
      endcase
    end
    start_scan();
    wait_done("scan3_done");

    // scan 4: reset during WAIT_DONE of cell 50, then a full rescan
    for (int c = 0; c < NCELL; c++) mem[c] = 8'd1;
    start_scan();
    cnt = 0;
    while (!(draws_seen == 51 && drawer_active) && cnt < 10000) begin
      @(negedge clk); #1;
      cnt++;
    end
    chk_ok("reach_cell50", cnt < 10000, draws_seen, 51);
    @(posedge clk); #2;
    chk_eq("pre_reset_cells", int'(cells_drawn), 51);
    chk_eq("pre_reset_x", int'(x_pos), 80);
    chk_eq("pre_reset_y", int'(y_pos), 16);
    resetn = 1'b0;
    #1;
    chk_eq("arst_map_addr", int'(map_addr), 0);
    chk_eq("arst_tile_address", int'(tile_address), 0);
    chk_eq("arst_xy", int'({x_pos, y_pos}), 0);
    chk_eq("arst_draw", int'(draw), 0);
    chk_eq("arst_busy", int'(busy), 0);
    chk_eq("arst_done", int'(done), 0);
    chk_eq("arst_cells_drawn", int'(cells_drawn), 0);
    repeat (2) @(negedge clk);
    q.delete();
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("post_reset_busy", int'(busy), 0);
    for (int c = 0; c < NCELL; c++) mem[c] = 8'($urandom_range(0, 24));
    start_scan();
    wait_done("scan4_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
